// File: rtl/prefetch_queue.sv
// Byte-wide instruction prefetch queue: word/odd-byte pushes from the BIU,
// single-byte show-ahead pops for the EU, flush on control transfer.
module prefetch_queue #(
  parameter int DEPTH = 6,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [15:0]   wr_data,
  input  logic          wr_odd,
  output logic          wr_ready,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] ROOM_LIMIT = CW'(DEPTH - 2);
  localparam logic [PW-1:0] LAST_SLOT  = PW'(DEPTH - 1);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          push, reject, pop;
  logic [PW-1:0] tail_p1, tail_p2;
  logic [CW-1:0] nwr, nrd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  // Status outputs depend on registered state only.
  always_comb begin
    wr_ready = (count_q <= ROOM_LIMIT);
    rd_valid = (count_q != '0);
    rd_data  = mem_q[head_q];
    count    = count_q;
    ovf      = ovf_q;
  end

  always_comb begin
    push    = wr_en & wr_ready & ~flush;
    reject  = wr_en & ~wr_ready & ~flush;
    pop     = rd_en & rd_valid & ~flush;
    tail_p1 = ptr_inc(tail_q);
    tail_p2 = ptr_inc(tail_p1);
    nwr     = '0;
    nrd     = pop ? CW'(1) : '0;
    mem_d   = mem_q;
    tail_d  = tail_q;
    head_d  = pop ? ptr_inc(head_q) : head_q;
    ovf_d   = ovf_q | reject;

    if (push) begin
      if (wr_odd) begin
        mem_d[tail_q] = wr_data[15:8];
        tail_d        = tail_p1;
        nwr           = CW'(1);
      end else begin
        mem_d[tail_q]  = wr_data[7:0];
        mem_d[tail_p1] = wr_data[15:8];
        tail_d         = tail_p2;
        nwr            = CW'(2);
      end
    end

    count_d = count_q + nwr - nrd;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Byte storage is intentionally left uncleared by reset and flush.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed and randomized checks of prefetch_queue against a byte-queue model.
module tb_prefetch_queue;

  localparam int DEPTH = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, flush, wr_en, wr_odd, rd_en;
  logic [15:0]   wr_data;
  logic          wr_ready, rd_valid, ovf;
  logic [7:0]    rd_data;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq [$];
  logic       m_ovf;

  prefetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_odd   (wr_odd),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: a plain byte queue; status derived from its size before the edge.
  task automatic model_edge(input logic r, input logic f, input logic we,
                            input logic [15:0] wd, input logic wo, input logic re);
    int  sz;
    bit  rdy, vld;
    sz  = mq.size();
    rdy = (DEPTH - sz) >= 2;
    vld = sz != 0;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (f) begin
      mq.delete();
    end else begin
      if (we && !rdy) m_ovf = 1'b1;
      if (re && vld) void'(mq.pop_front());
      if (we && rdy) begin
        if (wo) mq.push_back(wd[15:8]);
        else begin
          mq.push_back(wd[7:0]);
          mq.push_back(wd[15:8]);
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".count"}, 32'(count), 32'(mq.size()));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(mq.size() != 0));
    check({tag, ".wr_ready"}, 32'(wr_ready), 32'((DEPTH - mq.size()) >= 2));
    check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    if (mq.size() != 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
  endtask

  task automatic step(input string tag, input logic r, input logic f, input logic we,
                      input logic [15:0] wd, input logic wo, input logic re);
    reset = r; flush = f; wr_en = we; wr_data = wd; wr_odd = wo; rd_en = re;
    @(posedge clk);
    model_edge(r, f, we, wd, wo, re);
    #1;
    reset = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_odd = 1'b0;
    compare_model(tag);
  endtask

  task automatic push_w(input string tag, input logic [15:0] wd);
    step(tag, 1'b0, 1'b0, 1'b1, wd, 1'b0, 1'b0);
  endtask

  task automatic pop1(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    m_ovf = 1'b0;
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = '0; wr_odd = 1'b0; rd_en = 1'b0;

    step("reset", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    check("reset_ovf", 32'(ovf), 32'd0);
    pop1("idle_pop0");
    pop1("idle_pop1");
    check("idle_count", 32'(count), 32'd0);

    push_w("word_push", 16'hBBAA);
    check("word_lo", 32'(rd_data), 32'hAA);
    check("word_count2", 32'(count), 32'd2);
    pop1("word_pop0");
    check("word_hi", 32'(rd_data), 32'hBB);
    check("word_count1", 32'(count), 32'd1);
    pop1("word_pop1");
    check("word_empty", 32'(rd_valid), 32'd0);

    step("odd_push", 1'b0, 1'b0, 1'b1, 16'h12CD, 1'b1, 1'b0);
    check("odd_count", 32'(count), 32'd1);
    check("odd_data", 32'(rd_data), 32'h12);
    pop1("odd_pop");

    // Start the wrap test from slot 0.
    step("wrap_flush", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    push_w("wrap_p0", 16'h0201);
    push_w("wrap_p1", 16'h0403);
    push_w("wrap_p2", 16'h0605);
    for (int i = 0; i < 5; i++) pop1("wrap_drain");
    check("wrap_count1", 32'(count), 32'd1);
    push_w("wrap_p3", 16'h0807);
    push_w("wrap_p4", 16'h0A09);
    for (int i = 0; i < 5; i++) begin
      check("wrap_seq", 32'(rd_data), 32'(8'h06 + i));
      pop1("wrap_pop");
    end
    check("wrap_empty", 32'(rd_valid), 32'd0);

    push_w("full_p0", 16'h1111);
    push_w("full_p1", 16'h2222);
    push_w("full_p2", 16'h3333);
    check("full_count", 32'(count), 32'd6);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    step("ovf_push", 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_count", 32'(count), 32'd5);
    pop1("drain_to4");
    check("drain_wr_ready", 32'(wr_ready), 32'd1);
    check("drain_ovf_kept", 32'(ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("no_ff_byte", 32'(rd_data == 8'hFF), 32'd0);
      pop1("drain");
    end

    push_w("fl_p0", 16'h5566);
    step("fl_p1", 1'b0, 1'b0, 1'b1, 16'h7700, 1'b1, 1'b0);
    check("fl_count3", 32'(count), 32'd3);
    step("flush_all", 1'b0, 1'b1, 1'b1, 16'hABCD, 1'b0, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_rd_valid", 32'(rd_valid), 32'd0);
    check("flush_ovf", 32'(ovf), 32'd1);
    push_w("post_flush", 16'h3344);
    check("post_flush_data", 32'(rd_data), 32'h44);

    step("mid_reset", 1'b1, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b1);
    check("mid_reset_count", 32'(count), 32'd0);
    check("mid_reset_ovf", 32'(ovf), 32'd0);

    for (int n = 0; n < 400; n++) begin
      step("rand",
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1,
           16'($urandom),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Byte-wide instruction prefetch queue between the bus interface unit (writer) and the execution unit (reader). The BIU pushes 16-bit fetched words, or a single high byte after an odd-address fetch. The EU pops one opcode/operand byte per cycle from a show-ahead head. A flush discards all queued bytes on control transfer (jump, call, return, interrupt).

## Interface
Parameters:
- DEPTH, 6, queue capacity in bytes (≥ 2; need not be a power of two).
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued bytes.
- wr_en  in  1  push request from the BIU.
- wr_data  in  16  fetched word; [7:0] at the even address, [15:8] at the odd address.
- wr_odd  in  1  qualifies wr_en: 1 pushes wr_data[15:8] only; 0 pushes both bytes.
- wr_ready  out  1  (DEPTH − count) ≥ 2; BIU may fetch.
- rd_en  in  1  pop request from the EU.
- rd_data  out  8  head byte, show-ahead.
- rd_valid  out  1  count ≠ 0.
- count  out  CW  bytes currently queued.
- ovf  out  1  sticky error flag: a push was attempted while wr_ready = 0.

## Operation
- Storage: circular array of DEPTH bytes, plus head pointer, tail pointer and count.
- Pointer increment wraps from DEPTH−1 to 0. The 2-byte push places the second byte at (tail+1) mod DEPTH, so it may wrap between the two bytes.
- Push when wr_en & wr_ready & !flush:
  - wr_odd = 0: enqueue wr_data[7:0], then wr_data[15:8]; nwr = 2.
  - wr_odd = 1: enqueue wr_data[15:8]; nwr = 1.
- Rejected push (wr_en & !wr_ready & !flush):
  - Queue is unchanged.
  - ovf is set to 1 and stays set until reset.
- Pop when rd_en & rd_valid & !flush: head advances; nrd = 1.
- Pop when empty: ignored. No state change and no error.
- Normal update: count ← count + nwr − nrd.
- wr_ready and rd_valid are always evaluated on pre-edge state.
  - A same-cycle pop does not make room for a same-cycle push.
  - A same-cycle push does not satisfy a pop on an empty queue.
- flush has priority over push and pop in the same cycle: head ← 0, tail ← 0, count ← 0. ovf is not affected.
- Array contents are not cleared by reset or flush. rd_data is don't-care while rd_valid = 0.

## Timing
- Reset values: count = 0, rd_valid = 0, wr_ready = 1, ovf = 0, head = tail = 0.
- Write-to-read latency is 1 cycle: a byte pushed at edge N is visible on rd_data (with rd_valid = 1) after edge N.
- rd_data, rd_valid, wr_ready and count are combinational from registered state only. There are no input-to-output combinational paths.
- Pop throughput: one byte per cycle.
- Push throughput: one word per cycle while wr_ready = 1.
- Full boundary:
  - count = DEPTH−1 or DEPTH gives wr_ready = 0.
  - count = DEPTH−2 gives wr_ready = 1; a 2-byte push fills the queue to DEPTH.
- Reset mid-operation behaves like flush and additionally clears ovf, in the same cycle.
- Reset overrides all other inputs.

## Test plan
- Reset, then idle:
  - count = 0, rd_valid = 0, wr_ready = 1, ovf = 0.
  - rd_en pulses leave all outputs unchanged.
- Word order:
  - Push 16'hBBAA (wr_odd = 0) → next cycle rd_data = 8'hAA, count = 2.
  - Pop → rd_data = 8'hBB, count = 1.
  - Pop → rd_valid = 0.
- Odd push: push 16'h12CD with wr_odd = 1 → count = 1, rd_data = 8'h12.
- Wrap-around (DEPTH = 6):
  - Push 3 words 01..06 and pop 5 bytes; count = 1.
  - Push words 16'h0807 and 16'h0A09 → pop sequence is 06, 07, 08, 09, 0A, with correct bytes across the pointer wrap.
- Full and overflow:
  - Fill to 6 → wr_ready = 0.
  - Push 16'hFFFF with rd_en in the same cycle → push dropped, ovf = 1, count = 5, no FF byte is ever read.
  - Drain to 4 → wr_ready = 1; ovf remains 1.
- Flush priority:
  - With count = 3, assert flush, wr_en and rd_en together → count = 0, rd_valid = 0 next cycle, ovf unchanged.
  - Push 16'h3344 → rd_data = 8'h44 with head at slot 0.
